// File: rtl/tx_symbol_sequencer.sv
// TX framing scheduler: selects one symbol per enabled cycle (packet framing, SKP/FTS ordered sets, IDLE).
// Optional FTS ordered-set support is compiled in when TX_SEQ_FTS_EN is defined.
module tx_symbol_sequencer #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_COUNT    = 3,
  parameter int unsigned FTS_COUNT    = 4,
  parameter int unsigned CNT_W        = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       pkt_valid,
  input  logic       pkt_is_dllp,
  input  logic       pkt_last,
  input  logic       pkt_abort,
  output logic       pkt_ready,
  input  logic       fts_req,
  output logic       fts_done,
  output logic [3:0] control_dk,
  output logic       skp_pending,
  output logic       seq_busy
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SKP_COM = 4'd1;
  localparam logic [3:0] S_SKP     = 4'd2;
  localparam logic [3:0] S_START   = 4'd3;
  localparam logic [3:0] S_DATA    = 4'd4;
  localparam logic [3:0] S_END     = 4'd5;
  localparam logic [3:0] S_EDB     = 4'd6;
`ifdef TX_SEQ_FTS_EN
  localparam logic [3:0] S_FTS_COM = 4'd7;
  localparam logic [3:0] S_FTS     = 4'd8;
  localparam logic [3:0] DK_FTS    = 4'd7;
  localparam logic [2:0] FTS_LAST  = 3'(FTS_COUNT - 1);
`endif

  localparam logic [3:0] DK_DATA = 4'd0;
  localparam logic [3:0] DK_COM  = 4'd1;
  localparam logic [3:0] DK_SKP  = 4'd2;
  localparam logic [3:0] DK_STP  = 4'd3;
  localparam logic [3:0] DK_SDP  = 4'd4;
  localparam logic [3:0] DK_END  = 4'd5;
  localparam logic [3:0] DK_EDB  = 4'd6;
  localparam logic [3:0] DK_IDLE = 4'd8;

  localparam logic [2:0]       SKP_LAST = 3'(SKP_COUNT - 1);
  localparam logic [CNT_W-1:0] SKP_MAX  = CNT_W'(SKP_INTERVAL - 1);

  logic [3:0]       state, state_n;
  logic [2:0]       sym_cnt, sym_n;
  logic             is_dllp, dllp_n;
  logic [CNT_W-1:0] skp_cnt, skp_cnt_n;
  logic             pend_n;
  logic [3:0]       dk_n;
  logic             decide;

  assign pkt_ready = enb && (state == S_DATA);
  assign seq_busy  = (state != S_IDLE);

  always_comb begin
    state_n = state;
    sym_n   = sym_cnt;
    dllp_n  = is_dllp;
    decide  = 1'b0;
    case (state)
      S_IDLE, S_END, S_EDB: decide = 1'b1;
      S_SKP_COM: begin
        state_n = S_SKP;
        sym_n   = '0;
      end
      S_SKP: begin
        if (sym_cnt == SKP_LAST) decide = 1'b1;
        else sym_n = sym_cnt + 3'd1;
      end
      S_START: state_n = S_DATA;
      S_DATA: begin
        // Abort and underrun both nullify; abort wins over last.
        if (!pkt_valid || pkt_abort) state_n = S_EDB;
        else if (pkt_last)           state_n = S_END;
      end
`ifdef TX_SEQ_FTS_EN
      S_FTS_COM: begin
        state_n = S_FTS;
        sym_n   = '0;
      end
      S_FTS: begin
        if (sym_cnt == FTS_LAST) decide = 1'b1;
        else sym_n = sym_cnt + 3'd1;
      end
`endif
      default: state_n = S_IDLE;
    endcase

    if (decide) begin
      if (skp_pending) state_n = S_SKP_COM;
`ifdef TX_SEQ_FTS_EN
      else if (fts_req) state_n = S_FTS_COM;
`endif
      else if (pkt_valid) begin
        state_n = S_START;
        dllp_n  = pkt_is_dllp;
      end
      else state_n = S_IDLE;
    end
  end

  always_comb begin
    dk_n = DK_IDLE;
    case (state_n)
      S_SKP_COM: dk_n = DK_COM;
      S_SKP:     dk_n = DK_SKP;
      S_START:   dk_n = dllp_n ? DK_SDP : DK_STP;
      S_DATA:    dk_n = DK_DATA;
      S_END:     dk_n = DK_END;
      S_EDB:     dk_n = DK_EDB;
`ifdef TX_SEQ_FTS_EN
      S_FTS_COM: dk_n = DK_COM;
      S_FTS:     dk_n = DK_FTS;
`endif
      default:   dk_n = DK_IDLE;
    endcase
  end

  // Timer saturates at SKP_MAX; pending rises on the edge the count reaches it.
  always_comb begin
    if (state_n == S_SKP_COM) begin
      skp_cnt_n = '0;
      pend_n    = 1'b0;
    end else begin
      skp_cnt_n = (skp_cnt == SKP_MAX) ? skp_cnt : skp_cnt + CNT_W'(1);
      pend_n    = skp_pending || (skp_cnt_n == SKP_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      control_dk  <= DK_IDLE;
      sym_cnt     <= '0;
      is_dllp     <= 1'b0;
      skp_cnt     <= '0;
      skp_pending <= 1'b0;
    end else if (enb) begin
      state       <= state_n;
      control_dk  <= dk_n;
      sym_cnt     <= sym_n;
      is_dllp     <= dllp_n;
      skp_cnt     <= skp_cnt_n;
      skp_pending <= pend_n;
    end
  end

`ifdef TX_SEQ_FTS_EN
  always_ff @(posedge clk) begin
    if (rst)      fts_done <= 1'b0;
    else if (enb) fts_done <= (state_n == S_FTS) && (sym_n == FTS_LAST);
  end
`else
  logic unused_fts;
  assign unused_fts = fts_req | (FTS_COUNT == 0);
  assign fts_done   = 1'b0;
`endif

endmodule

// File: tb/tb_tx_symbol_sequencer.sv
// Directed vector bench for tx_symbol_sequencer (SKP_INTERVAL=16, SKP_COUNT=3, FTS_COUNT=4).
module tb_tx_symbol_sequencer;

  logic       clk = 1'b0;
  logic       rst, enb, pkt_valid, pkt_is_dllp, pkt_last, pkt_abort, fts_req;
  logic       pkt_ready, fts_done, skp_pending, seq_busy;
  logic [3:0] control_dk;

  int n_cmp = 0;
  int n_bad = 0;

  tx_symbol_sequencer #(
    .SKP_INTERVAL(16),
    .SKP_COUNT(3),
    .FTS_COUNT(4),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enb(enb),
    .pkt_valid(pkt_valid),
    .pkt_is_dllp(pkt_is_dllp),
    .pkt_last(pkt_last),
    .pkt_abort(pkt_abort),
    .pkt_ready(pkt_ready),
    .fts_req(fts_req),
    .fts_done(fts_done),
    .control_dk(control_dk),
    .skp_pending(skp_pending),
    .seq_busy(seq_busy)
  );

  always #5 clk = ~clk;

  // Inputs packed as {rst, enb, valid, dllp, last, abort, fts}.
  typedef struct {
    logic [6:0] in;
    logic       ready;
    int         dk;
    logic       pend;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  localparam logic [6:0] RST  = 7'b1100000;
  localparam logic [6:0] IDL  = 7'b0100000;
  localparam logic [6:0] TLP  = 7'b0110000;
  localparam logic [6:0] DLP  = 7'b0111000;

  task automatic add(input logic [6:0] in, input logic ready, input int dk,
                     input logic pend, input logic done);
    vec_t v;
    v.in = in; v.ready = ready; v.dk = dk; v.pend = pend; v.done = done;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] in);
    {rst, enb, pkt_valid, pkt_is_dllp, pkt_last, pkt_abort, fts_req} = in;
  endtask

  initial begin
    drive(IDL);

    // Reset
    add(RST, 0, 8, 0, 0);
    add(RST, 0, 8, 0, 0);

    // 4-byte TLP with an enb=0 stall mid-packet
    add(TLP,        0, 3, 0, 0);
    add(TLP,        0, 0, 0, 0);
    add(TLP,        1, 0, 0, 0);
    add(TLP,        1, 0, 0, 0);
    add(7'b0010000, 0, 0, 0, 0);
    add(TLP,        1, 0, 0, 0);
    add(7'b0110100, 1, 5, 0, 0);
    add(IDL,        0, 8, 0, 0);

    // DLLP then TLP back to back
    add(RST,        0, 8, 0, 0);
    add(DLP,        0, 4, 0, 0);
    add(DLP,        0, 0, 0, 0);
    add(DLP,        1, 0, 0, 0);
    add(7'b0111100, 1, 5, 0, 0);
    add(TLP,        0, 3, 0, 0);
    add(TLP,        0, 0, 0, 0);
    add(TLP,        1, 0, 0, 0);
    add(7'b0110100, 1, 5, 0, 0);
    add(IDL,        0, 8, 0, 0);

    // Abort (with last also set) on byte 2
    add(RST,        0, 8, 0, 0);
    add(TLP,        0, 3, 0, 0);
    add(TLP,        0, 0, 0, 0);
    add(TLP,        1, 0, 0, 0);
    add(7'b0110110, 1, 6, 0, 0);
    add(IDL,        0, 8, 0, 0);

    // Underrun after byte 1
    add(RST,        0, 8, 0, 0);
    add(TLP,        0, 3, 0, 0);
    add(TLP,        0, 0, 0, 0);
    add(TLP,        1, 0, 0, 0);
    add(IDL,        1, 6, 0, 0);
    add(IDL,        0, 8, 0, 0);

`ifdef TX_SEQ_FTS_EN
    // SKP, then FTS, then packet, with enb stalls inside the FTS set
    add(RST, 0, 8, 0, 0);
    for (int i = 0; i < 14; i++) add(IDL, 0, 8, 0, 0);
    add(IDL,        0, 8, 1, 0);
    add(7'b0110001, 0, 1, 0, 0);
    add(7'b0110001, 0, 2, 0, 0);
    add(7'b0110001, 0, 2, 0, 0);
    add(7'b0110001, 0, 2, 0, 0);
    add(7'b0110001, 0, 1, 0, 0);
    add(7'b0110001, 0, 7, 0, 0);
    add(7'b0010001, 0, 7, 0, 0);
    add(7'b0110001, 0, 7, 0, 0);
    add(7'b0110001, 0, 7, 0, 0);
    add(TLP,        0, 7, 0, 1);
    add(7'b0010000, 0, 7, 0, 1);
    add(TLP,        0, 3, 0, 0);
    add(TLP,        0, 0, 0, 0);
    add(IDL,        1, 6, 0, 0);
    add(IDL,        0, 8, 0, 0);
`else
    // fts_req has no effect
    add(RST,        0, 8, 0, 0);
    add(7'b0100001, 0, 8, 0, 0);
    add(7'b0110001, 0, 3, 0, 0);
    add(7'b0100001, 0, 0, 0, 0);
    add(7'b0100001, 1, 6, 0, 0);
    add(IDL,        0, 8, 0, 0);
`endif

    // 10-byte packet straddling the SKP deadline; SKP set follows END
    add(RST, 0, 8, 0, 0);
    for (int i = 0; i < 4; i++) add(IDL, 0, 8, 0, 0);
    add(TLP, 0, 3, 0, 0);
    add(TLP, 0, 0, 0, 0);
    for (int e = 7; e <= 15; e++) add(TLP, 1, 0, (e >= 15), 0);
    add(7'b0110100, 1, 5, 1, 0);
    add(IDL, 0, 1, 0, 0);
    add(IDL, 0, 2, 0, 0);
    add(IDL, 0, 2, 0, 0);
    add(IDL, 0, 2, 0, 0);
    add(IDL, 0, 8, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in);
      #1;
      if (!vecs[i].in[6]) chk($sformatf("row%0d pkt_ready", i), int'(pkt_ready), int'(vecs[i].ready));
      tick();
      chk($sformatf("row%0d control_dk", i), int'(control_dk), vecs[i].dk);
      chk($sformatf("row%0d skp_pending", i), int'(skp_pending), int'(vecs[i].pend));
      chk($sformatf("row%0d seq_busy", i), int'(seq_busy), int'(vecs[i].dk != 8));
      chk($sformatf("row%0d fts_done", i), int'(fts_done), int'(vecs[i].done));
    end

    // SKP counter restarted at 0 on COM entry; it now reads 4. Stalls must not advance it.
    drive(7'b0000000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall skp_pending", int'(skp_pending), 0);
      chk("stall control_dk", int'(control_dk), 8);
    end
    drive(IDL);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("restart cnt%0d skp_pending", i + 5), int'(skp_pending), 0);
    end
    tick();
    chk("restart cnt15 skp_pending", int'(skp_pending), 1);
    chk("restart cnt15 control_dk", int'(control_dk), 8);
    tick();
    chk("second skp control_dk", int'(control_dk), 1);
    chk("second skp skp_pending", int'(skp_pending), 0);
    chk("second skp seq_busy", int'(seq_busy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_symbol_sequencer.md
Name: tx_symbol_sequencer

Overview:
- Transmit-side framing scheduler for the PHY TX path; drives the 4-bit symbol-select code of the TX symbol multiplexer one symbol per enabled clock.
- Frames data-layer packets with start (STP/SDP) and end (END/EDB) symbols and inserts periodic COM+SKP ordered sets between packets.
- Fills idle gaps with IDLE; accepts packet bytes through a valid/ready handshake.

Parameters:
- SKP_INTERVAL, 1180, enabled cycles between SKP ordered-set requests.
- SKP_COUNT, 3, SKP symbols after COM in one SKP ordered set (1..7).
- FTS_COUNT, 4, FTS symbols after COM in one FTS ordered set (1..7).
- CNT_W, 11, SKP interval counter width; 2^CNT_W > SKP_INTERVAL.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enb  in  1  symbol-cycle enable; low freezes all state.
- pkt_valid  in  1  data layer has a byte on the mux data input.
- pkt_is_dllp  in  1  sampled at packet start: 1 = DLLP (SDP), 0 = TLP (STP).
- pkt_last  in  1  current byte is the last of the packet.
- pkt_abort  in  1  nullify current packet.
- pkt_ready  out  1  byte consumed this cycle.
- fts_req  in  1  request an FTS ordered set (level).
- fts_done  out  1  one-cycle pulse on the last FTS symbol.
- control_dk  out  4  symbol select: 0 DATA, 1 COM, 2 SKP, 3 STP, 4 SDP, 5 END, 6 EDB, 7 FTS, 8 IDLE.
- skp_pending  out  1  SKP ordered set owed.
- seq_busy  out  1  state != S_IDLE.

Behaviour:
- Reset (rst=1 at clk edge): state S_IDLE, control_dk=8, skp counter=0, skp_pending=0, fts_done=0, symbol counter=0. Reset mid-packet or mid-ordered-set abandons it; no END/EDB emitted.
- enb=0: state, counters, control_dk and fts_done held; pkt_ready=0.
- States: S_IDLE, S_SKP_COM, S_SKP, S_START, S_DATA, S_END, S_EDB, S_FTS_COM, S_FTS.
- control_dk is registered; it equals the code of the current state's symbol: IDLE 8, SKP_COM/FTS_COM 1, SKP 2, START 3 or 4 from the latched type, DATA 0, END 5, EDB 6, FTS 7.
- pkt_ready = enb && state==S_DATA (combinational). Bytes are consumed in the same cycle the mux passes data.
- Decision point is in S_IDLE, S_END, S_EDB, and the last symbol of an ordered set. Next state is chosen by priority:
  - skp_pending -> S_SKP_COM.
  - fts_req (macro on) -> S_FTS_COM.
  - pkt_valid -> S_START, latching pkt_is_dllp.
  - otherwise -> S_IDLE.
- Back-to-back packets therefore need no IDLE between END and the next STP/SDP.
- S_START always goes to S_DATA. Packet latency: pkt_valid seen in S_IDLE, start symbol next cycle, first byte consumed the cycle after.
- S_DATA transitions:
  - pkt_valid && pkt_abort -> S_EDB; the byte is consumed but nullified.
  - else pkt_valid && pkt_last -> S_END.
  - else pkt_valid -> stay in S_DATA.
  - pkt_valid=0 (underrun) -> S_EDB; no byte consumed.
  - pkt_abort has priority over pkt_last.
- SKP ordered set: S_SKP_COM for 1 cycle, then S_SKP for exactly SKP_COUNT cycles via the symbol counter.
- SKP timer:
  - Counts every enabled cycle, including during packets.
  - At SKP_INTERVAL-1 it sets skp_pending and saturates.
  - Entering S_SKP_COM clears the counter to 0 and clears skp_pending the same edge.
  - Insertion never splits a packet.

Optional Feature:
- TX_SEQ_FTS_EN defined: fts_req participates in the decision (below SKP, above packets).
  - The FTS ordered set is S_FTS_COM for 1 cycle, then S_FTS for FTS_COUNT cycles.
  - fts_done pulses during the last FTS symbol.
  - fts_req must drop before the next decision point or another ordered set follows.
- Not defined: fts_req ignored, fts_done tied 0, FTS states absent.

Test Plan:
- Reset with rst=1 for 2 cycles -> control_dk=8, pkt_ready=0, skp_pending=0, seq_busy=0.
- 4-byte TLP (pkt_is_dllp=0, pkt_last on byte 4) -> control_dk sequence 3,0,0,0,0,5,8; pkt_ready high exactly 4 cycles.
- DLLP followed immediately by TLP (pkt_valid held) -> ...0,5,4,0...,0,5,3,0...; no 8 between packets.
- Abort on byte 2, and separately pkt_valid dropped in S_DATA -> control_dk 0,6 then 8; aborted byte consumed, underrun byte not.
- SKP_INTERVAL=16, SKP_COUNT=3, 10-byte packet straddling cycle 15 -> skp_pending rises at count 15; after END 5 comes 1,2,2,2, then 8; counter restarts at 0.
- TX_SEQ_FTS_EN, FTS_COUNT=4, fts_req with simultaneous skp_pending and pkt_valid -> 1,2,2,2 then 1,7,7,7,7 (fts_done on 4th 7) then 3. enb toggling mid-sequence stretches it without changing its order.
